// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: operation codes and
// controller states.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv.sv
// Multi-cycle signed/unsigned multiply and restoring divide with HI/LO registers.
// state | meaning: IDLE accept/MTHI/MTLO, RUN one bit per cycle, FIX sign fix + write
module muldiv
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N + 1);

  muldiv_state_t  state;
  muldiv_state_t  state_next;
  muldiv_op_t     op_code;

  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [N-1:0]   opnd;
  logic           is_div;
  logic           neg_res;
  logic           neg_rem;

  logic           accept;
  logic           is_mul_req;
  logic           is_div_req;
  logic           zero_div;
  logic           launch;
  logic           signed_req;
  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;

  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  logic [N:0]     rem_shift;
  logic [N:0]     rem_diff;
  logic           div_ge;
  logic [2*N-1:0] div_next;

  logic [N-1:0]   quo_raw;
  logic [N-1:0]   rem_raw;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;
  logic [2*N-1:0] prod_fix;

  always_comb begin
    op_code    = muldiv_op_t'(op);
    accept     = start && (state == ST_IDLE);
    is_mul_req = accept && ((op_code == OP_MULT) || (op_code == OP_MULTU));
    is_div_req = accept && ((op_code == OP_DIV) || (op_code == OP_DIVU));
    zero_div   = is_div_req && (b == '0);
    launch     = is_mul_req || (is_div_req && !zero_div);
    signed_req = (op_code == OP_MULT) || (op_code == OP_DIV);
    a_neg      = signed_req && a[N-1];
    b_neg      = signed_req && b[N-1];
    a_mag      = a_neg ? -a : a;
    b_mag      = b_neg ? -b : b;
  end

  // Multiply: add multiplicand into the upper half when the low bit is set,
  // then shift the whole register right (carry enters at the top).
  always_comb begin
    mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
    mul_next = {mul_sum, acc[N-1:1]};
  end

  // Divide: shift the next dividend bit into the partial remainder and
  // subtract the divisor when it fits; quotient bits enter at the bottom.
  always_comb begin
    rem_shift = acc[2*N-1:N-1];
    rem_diff  = rem_shift - {1'b0, opnd};
    div_ge    = (rem_shift >= {1'b0, opnd});
    if (div_ge) begin
      div_next = {rem_diff[N-1:0], acc[N-2:0], 1'b1};
    end else begin
      div_next = {rem_shift[N-1:0], acc[N-2:0], 1'b0};
    end
  end

  always_comb begin
    quo_raw  = acc[N-1:0];
    rem_raw  = acc[2*N-1:N];
    quo_fix  = neg_res ? -quo_raw : quo_raw;
    rem_fix  = neg_rem ? -rem_raw : rem_raw;
    prod_fix = neg_res ? -acc : acc;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (launch) state_next = ST_RUN;
      ST_RUN:  if (cnt == CW'(1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      opnd        <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && (op_code == OP_MTHI)) hi <= a;
          if (accept && (op_code == OP_MTLO)) lo <= a;
          if (zero_div) begin
            done        <= 1'b1;
            div_by_zero <= 1'b1;
          end
          if (launch) begin
            acc     <= {{N{1'b0}}, a_mag};
            opnd    <= b_mag;
            cnt     <= CW'(N);
            is_div  <= is_div_req;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
          end
        end
        ST_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CW'(1);
        end
        ST_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*N-1:N];
            lo <= prod_fix[N-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: transaction-level reference model compared
// every cycle, directed corner cases, then randomized operations.
module tb_muldiv;
  import muldiv_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv #(.N(N)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] reference(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx;
    int          sy;
    longint      sp;
    logic [63:0] r;
    sx = x;
    sy = y;
    r  = '0;
    case (o)
      3'd0: begin
        sp = longint'(sx) * longint'(sy);
        r  = sp;
      end
      3'd1: r = {32'h0, x} * {32'h0, y};
      3'd2: begin
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {sx % sy, sx / sy};
      end
      3'd3: r = {x % y, x / y};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;
  logic [63:0]  m_res = '0;
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dbz = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    m_dbz  = 1'b0;
    chk_en = 1'b1;
    if (!reset_n) begin
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi   = m_res[63:32];
        m_lo   = m_res[31:0];
        m_done = 1'b1;
      end
    end else if (start) begin
      case (op)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          if (op[1] && b == '0) begin
            m_done = 1'b1;
            m_dbz  = 1'b1;
          end else begin
            m_res  = reference(op, a, b);
            m_left = N + 1;
          end
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy, m_left > 0);
      check("cyc_done", done, m_done);
      check("cyc_dbz", div_by_zero, m_dbz);
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (lat >= 2 * N) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout got=no_done exp=done t=%0t", name, $time);
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    issue(o, x, y);
    wait_done(name, lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    check({name, "_model_hi"}, m_hi, exp_hi);
    check({name, "_model_lo"}, m_lo, exp_lo);
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);

    run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    run("divu", 3'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    run("divu_zero", 3'd3, 32'h1234, 32'h0, 0, 32'h11, 32'h22);
    check("divu_zero_flag", div_by_zero, 1);
    check("divu_zero_busy", busy, 0);

    issue(3'd4, 32'hA5A5_A5A5, 32'h0);
    @(negedge clk);
    check("mthi_hi", hi, 32'hA5A5_A5A5);
    check("mthi_done", done, 0);
    issue(3'd5, 32'h5A5A_5A5A, 32'h0);
    @(negedge clk);
    check("mtlo_lo", lo, 32'h5A5A_5A5A);
    check("mtlo_done", done, 0);

    issue(3'd6, 32'hFFFF_0000, 32'h1);
    @(negedge clk);
    check("rsvd_hi", hi, 32'hA5A5_A5A5);
    check("rsvd_busy", busy, 0);

    issue(3'd1, 32'h1234, 32'h5678);
    repeat (5) @(posedge clk);
    #1;
    op = 3'd3; a = 32'd9; b = 32'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("midrun", lat);
    check("midrun_lat", lat, 27);
    check("midrun_hi", hi, 32'h0);
    check("midrun_lo", lo, 32'h0626_0060);

    issue(3'd1, 32'hDEAD, 32'hBEEF);
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    repeat (40) @(posedge clk);
    #1;
    run("multu_small", 3'd1, 32'd6, 32'd7, 33, 32'd0, 32'd42);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), rnd(), rnd());
      for (int c = 0; c < 2 * N && m_left > 0; c++) begin
        if ($urandom_range(0, 15) == 0) begin
          op = 3'($urandom_range(0, 7)); a = rnd(); b = rnd(); start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
      end
      start = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv.md
# muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, the sequential companion to the single-cycle ALU in the MIPS datapath. It executes signed and unsigned multiply and divide over `N`-bit operands using a one-bit-per-cycle shift/add and restoring-divide datapath, and exposes HI/LO so the ALU result mux can source MFHI/MFLO. A start/busy/done handshake lets the controller stall the pipeline while an operation is in flight.

## Interface
- `N`, default 32: operand width; HI and LO are each `N` bits; `N` ≥ 4.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  operation code (`muldiv_op_t`): MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101; 110/111 reserved, ignored.
- `a`  in  N  operand A / dividend / MTHI-MTLO source.
- `b`  in  N  operand B / divisor.
- `busy`  out  1  operation in flight; new `start` ignored.
- `done`  out  1  one-cycle pulse: HI/LO hold the final result.
- `div_by_zero`  out  1  one-cycle pulse with `done` when a DIV/DIVU had `b`=0.
- `hi`  out  N  HI register (product upper half / remainder).
- `lo`  out  N  LO register (product lower half / quotient).

## Operation
- States: IDLE, RUN, FIX. IDLE→RUN on accepted MULT/MULTU/DIV/DIVU with nonzero divisor (multiplies always); RUN→FIX after `N` iterations; FIX→IDLE unconditionally.
- Accept: `start`=1 in IDLE. `a`, `b`, `op` latched; later changes ignored until `done`.
- Signed ops: latch magnitudes and sign flags; MULT negates 2N-bit product if signs differ; DIV negates quotient if signs differ, remainder takes dividend's sign.
- DIV overflow (most-negative ÷ −1): LO = most-negative (wraps), HI = 0; no flag.
- Divide by zero (DIV/DIVU, `b`=0): no RUN; HI/LO unchanged; `done` and `div_by_zero` pulse one cycle after accept.
- MTHI/MTLO: write `a` to HI/LO at the accepting edge; no `busy`, no `done`.
- Reserved `op` with `start`: no effect.
- HI/LO change only at FIX completion, MTHI/MTLO, or reset; they read stable during RUN.

## Timing
- Reset (`reset_n`=0 at rising edge): state IDLE, `hi`=`lo`=0, `busy`=`done`=`div_by_zero`=0. Reset mid-operation aborts with no HI/LO write.
- Accept at edge k: `busy`=1 from after edge k through edge k+N+1 (N+1 cycles).
- Edges k+1..k+N: one iteration each. Edge k+N+1 (FIX): sign correction, HI/LO written, `busy`→0, `done`→1 for one cycle.
- Total latency start→`done` = N+1 cycles (33 at N=32).
- `start` may be asserted in the `done` cycle and is accepted (back-to-back).
- `start` while `busy`=1: ignored, no queuing.
- Outputs all registered; no combinational input→output path.

## Structure
- Package `muldiv_pkg`: `muldiv_op_t` enum (codes above), `muldiv_state_t` enum (IDLE, RUN, FIX).
- Single module; iteration counter width `$clog2(N+1)`. The shared 2N-bit shift register serves both multiply (product accumulate) and divide (remainder/quotient); no sub-module.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `done` 33 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=−3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=−7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU b=0 with hi=0x11, lo=0x22 -> `done`+`div_by_zero` one cycle after accept, hi/lo unchanged, `busy` never set.
- MTHI a=0xA5A5A5A5 then MTLO a=0x5A5A5A5A -> hi/lo updated next cycle, `done` stays 0; `start` pulsed mid-RUN ignored (result matches first op).
- `reset_n`=0 at RUN cycle 10 -> next cycle busy=0, hi=lo=0, no `done`; new MULTU 6×7 -> lo=42, hi=0.
